// File: rtl/pc_load_sequencer_if.sv
// Preset/clear drive bundle between a PC register loader and its control path.
// The slave modport is the sequencer side; the master modport is the control path / register side.
interface pc_load_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             load_req;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] preset_out;
  logic [WIDTH-1:0] clear_out;
  logic             busy;
  logic             load_ack;
  logic             load_err;

  modport master (
    output load_req,
    output load_value,
    output q_in,
    input  preset_out,
    input  clear_out,
    input  busy,
    input  load_ack,
    input  load_err
  );

  modport slave (
    input  load_req,
    input  load_value,
    input  q_in,
    output preset_out,
    output clear_out,
    output busy,
    output load_ack,
    output load_err
  );
endinterface

// File: rtl/pc_load_sequencer.sv
// Loads the preset/clear PC register: boot load of RESET_VECTOR, then req/ack loads.
// Define PC_LOAD_VERIFY_EN to enable readback comparison into load_err.
module pc_load_sequencer #(
  parameter int unsigned      WIDTH         = 32,
  parameter int unsigned      PULSE_CYCLES  = 2,
  parameter int unsigned      SETTLE_CYCLES = 1,
  parameter logic [WIDTH-1:0] RESET_VECTOR  = '0
) (
  input logic             clock,
  input logic             clear_n,
  pc_load_sequencer_if.slave bus
);
  localparam int unsigned CNT_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_PULSE,
    ST_SETTLE,
    ST_CHECK
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] value_reg, value_next;
  logic             boot_reg, boot_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [WIDTH-1:0] preset_reg, preset_next;
  logic [WIDTH-1:0] clear_reg, clear_next;
  logic             busy_reg, busy_next;
  logic             ack_reg, ack_next;
  logic             err_reg, err_next;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_reg  <= ST_BOOT;
      value_reg  <= RESET_VECTOR;
      boot_reg   <= 1'b1;
      cnt_reg    <= '0;
      preset_reg <= '0;
      clear_reg  <= '0;
      busy_reg   <= 1'b1;
      ack_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      value_reg  <= value_next;
      boot_reg   <= boot_next;
      cnt_reg    <= cnt_next;
      preset_reg <= preset_next;
      clear_reg  <= clear_next;
      busy_reg   <= busy_next;
      ack_reg    <= ack_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    value_next = value_reg;
    boot_next  = boot_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      ST_BOOT: begin
        state_next = ST_PULSE;
        value_next = RESET_VECTOR;
        boot_next  = 1'b1;
        cnt_next   = PULSE_LOAD;
      end
      ST_IDLE: begin
        if (bus.load_req) begin
          state_next = ST_PULSE;
          value_next = bus.load_value;
          boot_next  = 1'b0;
          cnt_next   = PULSE_LOAD;
        end
      end
      ST_PULSE: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else if (SETTLE_CYCLES == 0) begin
          state_next = ST_CHECK;
        end else begin
          state_next = ST_SETTLE;
          cnt_next   = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: state_next = ST_IDLE;
      default:  state_next = ST_BOOT;
    endcase
  end

  // Outputs are decoded from the upcoming state so every output leaves a flop.
  always_comb begin
    preset_next = '0;
    clear_next  = '0;
    busy_next   = (state_next != ST_IDLE);
    ack_next    = (state_next == ST_CHECK) && !boot_next;
    if (state_next == ST_PULSE) begin
      preset_next = value_next;
      clear_next  = ~value_next;
    end
`ifdef PC_LOAD_VERIFY_EN
    err_next = err_reg;
    if (state_next == ST_CHECK) begin
      err_next = (bus.q_in != value_reg);
    end
`else
    err_next = 1'b0;
`endif
  end

`ifndef PC_LOAD_VERIFY_EN
  logic unused_q_in;
  assign unused_q_in = ^bus.q_in;
`endif

  assign bus.preset_out = preset_reg;
  assign bus.clear_out  = clear_reg;
  assign bus.busy       = busy_reg;
  assign bus.load_ack   = ack_reg;
  assign bus.load_err   = err_reg;
endmodule

// File: tb/tb_pc_load_sequencer.sv
// Bench for pc_load_sequencer: directed vector table, corner sequences and random traffic
// against a per-cycle timeline model, on a default instance and a PULSE=1/SETTLE=0 instance.
module tb_pc_load_sequencer;
  localparam int W = 32;
  localparam logic [W-1:0] RV_A = 32'h0040_0000;
  localparam logic [W-1:0] RV_B = 32'h0000_0000;
`ifdef PC_LOAD_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] preset;
    logic [W-1:0] clr;
    logic         busy;
    logic         ack;
    logic         err;
  } exp_t;

  typedef struct packed {
    logic         req;
    logic [W-1:0] val;
    logic [W-1:0] e_preset;
    logic [W-1:0] e_clear;
    logic         e_busy;
    logic         e_ack;
  } vec_t;

  logic     clock = 1'b0;
  logic     clear_n = 1'b0;
  int       n_checks = 0;
  int       n_fail = 0;
  logic [W-1:0] reg_a = '0;
  logic [W-1:0] stuck0 = '0;
  exp_t     mq[2][$];
  exp_t     cur[2];
  logic     m_boot[2];
  logic     m_err[2];
  int       ack_cnt[2];
  vec_t     vtab[10];

  always #5 clock = ~clock;

  pc_load_sequencer_if #(.WIDTH(W)) bus_a ();
  pc_load_sequencer_if #(.WIDTH(W)) bus_b ();

  pc_load_sequencer #(
    .WIDTH(W), .PULSE_CYCLES(2), .SETTLE_CYCLES(1), .RESET_VECTOR(RV_A)
  ) dut_a (
    .clock(clock), .clear_n(clear_n), .bus(bus_a)
  );

  pc_load_sequencer #(
    .WIDTH(W), .PULSE_CYCLES(1), .SETTLE_CYCLES(0), .RESET_VECTOR(RV_B)
  ) dut_b (
    .clock(clock), .clear_n(clear_n), .bus(bus_b)
  );

  // Behavioural preset/clear register behind dut_a, with optional stuck-at-0 bits on Q.
  always @(bus_a.preset_out or bus_a.clear_out)
    reg_a = (reg_a | bus_a.preset_out) & ~bus_a.clear_out;
  assign bus_a.q_in = reg_a & ~stuck0;
  assign bus_b.q_in = '0;

  task automatic check_val(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_bit(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  // A sequence is a timeline: P drive cycles, S quiet cycles, one check cycle, one idle cycle.
  task automatic push_seq(int d, logic [W-1:0] v, logic is_load, logic [W-1:0] qmask);
    int   p;
    int   s;
    logic new_err;
    exp_t e;
    p = (d == 0) ? 2 : 1;
    s = (d == 0) ? 1 : 0;
    new_err = VERIFY && ((v & qmask) != v);
    e = '0;
    e.busy = 1'b1;
    e.err = m_err[d];
    e.preset = v;
    e.clr = ~v;
    for (int i = 0; i < p; i++) mq[d].push_back(e);
    e.preset = '0;
    e.clr = '0;
    for (int i = 0; i < s; i++) mq[d].push_back(e);
    e.ack = is_load;
    e.err = new_err;
    mq[d].push_back(e);
    e.ack = 1'b0;
    e.busy = 1'b0;
    mq[d].push_back(e);
    m_err[d] = new_err;
  endtask

  task automatic model_edge(int d, logic rstn, logic req, logic [W-1:0] val, logic [W-1:0] qmask);
    exp_t e;
    e = '0;
    if (!rstn) begin
      mq[d].delete();
      m_boot[d] = 1'b1;
      m_err[d] = 1'b0;
      e.busy = 1'b1;
      cur[d] = e;
    end else begin
      if (mq[d].size() == 0) begin
        if (m_boot[d]) begin
          push_seq(d, (d == 0) ? RV_A : RV_B, 1'b0, qmask);
          m_boot[d] = 1'b0;
        end else if (req) begin
          push_seq(d, val, 1'b1, qmask);
        end
      end
      if (mq[d].size() != 0) begin
        cur[d] = mq[d].pop_front();
      end else begin
        e.err = m_err[d];
        cur[d] = e;
      end
    end
  endtask

  task automatic check_dut(int d);
    logic [W-1:0] p;
    logic [W-1:0] c;
    logic b;
    logic a;
    logic e;
    string n;
    if (d == 0) begin
      p = bus_a.preset_out; c = bus_a.clear_out; b = bus_a.busy;
      a = bus_a.load_ack; e = bus_a.load_err; n = "a";
    end else begin
      p = bus_b.preset_out; c = bus_b.clear_out; b = bus_b.busy;
      a = bus_b.load_ack; e = bus_b.load_err; n = "b";
    end
    check_val({n, "_preset"}, p, cur[d].preset);
    check_val({n, "_clear"}, c, cur[d].clr);
    check_val({n, "_overlap"}, p & c, '0);
    check_bit({n, "_busy"}, b, cur[d].busy);
    check_bit({n, "_ack"}, a, cur[d].ack);
    check_bit({n, "_err"}, e, cur[d].err);
    if (a === 1'b1) begin
      ack_cnt[d]++;
      $display("dut_%s load acknowledged at %0t, load_err=%b", n, $time, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge(0, clear_n, bus_a.load_req, bus_a.load_value, ~stuck0);
    model_edge(1, clear_n, bus_b.load_req, bus_b.load_value, '0);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  initial begin
    int acks_before;
    bus_a.load_req = 1'b0;
    bus_a.load_value = '0;
    bus_b.load_req = 1'b0;
    bus_b.load_value = '0;
    m_boot = '{1'b1, 1'b1};
    m_err = '{1'b0, 1'b0};
    ack_cnt = '{0, 0};

    vtab[0] = '{1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h2152_4110, 1'b1, 1'b0};
    vtab[1] = '{1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 32'h2152_4110, 1'b1, 1'b0};
    vtab[2] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vtab[3] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1};
    vtab[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vtab[5] = '{1'b1, 32'h2222_2222, 32'h2222_2222, 32'hDDDD_DDDD, 1'b1, 1'b0};
    vtab[6] = '{1'b1, 32'h1111_1111, 32'h2222_2222, 32'hDDDD_DDDD, 1'b1, 1'b0};
    vtab[7] = '{1'b1, 32'h1111_1111, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vtab[8] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1};
    vtab[9] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};

    // Reset held for three edges, then the boot load of RESET_VECTOR.
    for (int i = 0; i < 3; i++) tick();
    check_val("reset_preset", bus_a.preset_out, 32'h0);
    check_bit("reset_busy", bus_a.busy, 1'b1);
    clear_n = 1'b1;
    tick();
    check_val("boot_c1_preset", bus_a.preset_out, 32'h0040_0000);
    check_val("boot_c1_clear", bus_a.clear_out, 32'hFFBF_FFFF);
    tick();
    check_val("boot_c2_preset", bus_a.preset_out, 32'h0040_0000);
    tick();
    check_val("boot_c3_preset", bus_a.preset_out, 32'h0);
    check_val("boot_c3_clear", bus_a.clear_out, 32'h0);
    tick();
    check_bit("boot_c4_ack", bus_a.load_ack, 1'b0);
    check_bit("boot_c4_busy", bus_a.busy, 1'b1);
    tick();
    check_bit("boot_c5_busy", bus_a.busy, 1'b0);
    check_bit("boot_err", bus_a.load_err, 1'b0);
    check_val("boot_ack_count", W'(ack_cnt[0]), W'(0));

    // Vector table: DEADBEEF load, then a 22222222 load with requests arriving while busy.
    acks_before = ack_cnt[0];
    for (int i = 0; i < 10; i++) begin
      bus_a.load_req = vtab[i].req;
      bus_a.load_value = vtab[i].val;
      tick();
      check_val($sformatf("vec%0d_preset", i), bus_a.preset_out, vtab[i].e_preset);
      check_val($sformatf("vec%0d_clear", i), bus_a.clear_out, vtab[i].e_clear);
      check_bit($sformatf("vec%0d_busy", i), bus_a.busy, vtab[i].e_busy);
      check_bit($sformatf("vec%0d_ack", i), bus_a.load_ack, vtab[i].e_ack);
    end
    check_val("table_ack_count", W'(ack_cnt[0] - acks_before), W'(2));

    // Readback mismatch with Q bit 0 stuck low, then a clean load replaces the flag.
    stuck0 = 32'h0000_0001;
    bus_a.load_req = 1'b1;
    bus_a.load_value = 32'h0000_0001;
    tick();
    bus_a.load_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_bit("mismatch_ack", bus_a.load_ack, 1'b1);
    check_bit("mismatch_err", bus_a.load_err, VERIFY);
    for (int i = 0; i < 3; i++) tick();
    check_bit("mismatch_err_idle", bus_a.load_err, VERIFY);
    stuck0 = '0;
    bus_a.load_req = 1'b1;
    bus_a.load_value = 32'h0000_0002;
    tick();
    bus_a.load_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_bit("recover_err", bus_a.load_err, 1'b0);
    tick();

    // Reset during the first pulse cycle of an all-ones load.
    acks_before = ack_cnt[0];
    bus_a.load_req = 1'b1;
    bus_a.load_value = 32'hFFFF_FFFF;
    tick();
    check_val("midrst_pulse", bus_a.preset_out, 32'hFFFF_FFFF);
    bus_a.load_req = 1'b0;
    clear_n = 1'b0;
    tick();
    check_val("midrst_preset", bus_a.preset_out, 32'h0);
    check_val("midrst_clear", bus_a.clear_out, 32'h0);
    clear_n = 1'b1;
    tick();
    check_val("reboot_preset", bus_a.preset_out, RV_A);
    for (int i = 0; i < 4; i++) tick();
    check_val("midrst_ack_count", W'(ack_cnt[0] - acks_before), W'(0));

    // Short-sequence instance: drive in cycle 1, ack in cycle 2.
    bus_b.load_req = 1'b1;
    bus_b.load_value = 32'h8000_0000;
    tick();
    check_val("sweep_preset", bus_b.preset_out, 32'h8000_0000);
    check_val("sweep_clear", bus_b.clear_out, 32'h7FFF_FFFF);
    bus_b.load_req = 1'b0;
    tick();
    check_bit("sweep_ack", bus_b.load_ack, 1'b1);
    check_bit("sweep_err", bus_b.load_err, VERIFY);
    tick();
    check_bit("sweep_idle_busy", bus_b.busy, 1'b0);

    // Random traffic on both instances with occasional resets.
    for (int c = 0; c < 400; c++) begin
      clear_n = ($urandom_range(0, 59) != 0);
      bus_a.load_req = ($urandom_range(0, 2) == 0);
      bus_a.load_value = $urandom();
      bus_b.load_req = ($urandom_range(0, 2) == 0);
      bus_b.load_value = $urandom();
      tick();
    end
    clear_n = 1'b1;
    bus_a.load_req = 1'b0;
    bus_b.load_req = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
